// File: rtl/ethernet_mmio_arbiter.sv
// Two-requester round-robin arbiter in front of a single MMIO controller.
// One access in flight at a time: accept (IDLE) -> strobe (ISSUE) -> optional
// read response wait (WAIT) with a bounded timeout.
module ethernet_mmio_arbiter #(
  parameter int unsigned axis_width_p = 64,
  parameter int unsigned timeout_p    = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [15:0]             r0_addr_i,
  input  logic                    r0_write_en_i,
  input  logic                    r0_read_en_i,
  input  logic [1:0]              r0_op_size_i,
  input  logic [axis_width_p-1:0] r0_write_data_i,
  output logic                    r0_ready_o,
  output logic [axis_width_p-1:0] r0_read_data_o,
  output logic                    r0_read_data_v_o,
  input  logic [15:0]             r1_addr_i,
  input  logic                    r1_write_en_i,
  input  logic                    r1_read_en_i,
  input  logic [1:0]              r1_op_size_i,
  input  logic [axis_width_p-1:0] r1_write_data_i,
  output logic                    r1_ready_o,
  output logic [axis_width_p-1:0] r1_read_data_o,
  output logic                    r1_read_data_v_o,
  output logic [15:0]             addr_o,
  output logic                    write_en_o,
  output logic                    read_en_o,
  output logic [1:0]              op_size_o,
  output logic [axis_width_p-1:0] write_data_o,
  input  logic [axis_width_p-1:0] read_data_i,
  input  logic                    read_data_v_i,
  output logic                    timeout_o,
  output logic                    proto_err_o
);

  localparam int unsigned        cnt_w     = $clog2(timeout_p + 1);
  localparam logic [cnt_w-1:0]   cnt_limit = cnt_w'(timeout_p);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              rst_sync_q;
  logic                    active;
  logic                    req0, req1, grant_sel, accept;
  logic                    sel_we, sel_re;
  logic [15:0]             addr_q;
  logic [1:0]              size_q;
  logic [axis_width_p-1:0] wdata_q;
  logic                    write_q, tag_q, last_q;
  logic [cnt_w-1:0]        cnt_q;

  // Two-flop release synchronizer; acceptance is held off until it fills.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_q <= '0;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign active = rst_sync_q[1];
  assign req0   = r0_write_en_i | r0_read_en_i;
  assign req1   = r1_write_en_i | r1_read_en_i;
  assign accept = (state_q == IDLE) && active && (req0 || req1);

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    if (req0 && req1) grant_sel = ~last_q;
    else              grant_sel = req1;
    sel_we = grant_sel ? r1_write_en_i : r0_write_en_i;
    sel_re = grant_sel ? r1_read_en_i  : r0_read_en_i;
  end

  // Capture the granted request; these registers also drive the shared bus.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      tag_q   <= 1'b0;
      last_q  <= 1'b1;
    end else if (accept) begin
      addr_q  <= grant_sel ? r1_addr_i       : r0_addr_i;
      size_q  <= grant_sel ? r1_op_size_i    : r0_op_size_i;
      wdata_q <= grant_sel ? r1_write_data_i : r0_write_data_i;
      write_q <= sel_we;
      tag_q   <= grant_sel;
      last_q  <= grant_sel;
    end
  end

  // Wait-cycle counter, cleared on the way into WAIT.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)              cnt_q <= '0;
    else if (state_q == ISSUE)   cnt_q <= '0;
    else if (state_q == WAIT)    cnt_q <= cnt_q + cnt_w'(1);
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  assign addr_o       = addr_q;
  assign op_size_o    = size_q;
  assign write_data_o = wdata_q;

  // Next-state and per-cycle outputs.
  always_comb begin
    state_d          = state_q;
    write_en_o       = 1'b0;
    read_en_o        = 1'b0;
    r0_ready_o       = 1'b0;
    r1_ready_o       = 1'b0;
    r0_read_data_o   = '0;
    r1_read_data_o   = '0;
    r0_read_data_v_o = 1'b0;
    r1_read_data_v_o = 1'b0;
    timeout_o        = 1'b0;
    proto_err_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // State reads IDLE throughout reset, so gate with the pin to keep outputs low.
        if (read_data_v_i && reset_n_i) proto_err_o = 1'b1;
        if (accept) begin
          r0_ready_o = ~grant_sel;
          r1_ready_o = grant_sel;
          if (sel_we && sel_re) proto_err_o = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        write_en_o = write_q;
        read_en_o  = ~write_q;
        if (read_data_v_i) proto_err_o = 1'b1;
        state_d = write_q ? IDLE : WAIT;
      end
      WAIT: begin
        if (read_data_v_i) begin
          if (tag_q) begin
            r1_read_data_o   = read_data_i;
            r1_read_data_v_o = 1'b1;
          end else begin
            r0_read_data_o   = read_data_i;
            r0_read_data_v_o = 1'b1;
          end
          state_d = IDLE;
        end else if (cnt_q == cnt_limit) begin
          r0_read_data_v_o = ~tag_q;
          r1_read_data_v_o = tag_q;
          timeout_o        = 1'b1;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ethernet_mmio_arbiter.sv
// Bench for ethernet_mmio_arbiter: directed scenarios with literal expectations
// followed by randomized requesters/controller checked against a
// transaction-level model every cycle.
module tb_ethernet_mmio_arbiter;

  localparam int W  = 64;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [15:0]   rq_addr [2];
  logic          rq_we   [2];
  logic          rq_re   [2];
  logic [1:0]    rq_size [2];
  logic [W-1:0]  rq_wd   [2];
  logic          r0_ready, r1_ready, r0_rdv, r1_rdv;
  logic [W-1:0]  r0_rd, r1_rd;
  logic [15:0]   addr;
  logic          we, re, tmo, perr;
  logic [1:0]    size;
  logic [W-1:0]  wdata, rdata;
  logic          rdv;

  ethernet_mmio_arbiter #(.axis_width_p(W), .timeout_p(TO)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .r0_addr_i(rq_addr[0]), .r0_write_en_i(rq_we[0]), .r0_read_en_i(rq_re[0]),
    .r0_op_size_i(rq_size[0]), .r0_write_data_i(rq_wd[0]),
    .r0_ready_o(r0_ready), .r0_read_data_o(r0_rd), .r0_read_data_v_o(r0_rdv),
    .r1_addr_i(rq_addr[1]), .r1_write_en_i(rq_we[1]), .r1_read_en_i(rq_re[1]),
    .r1_op_size_i(rq_size[1]), .r1_write_data_i(rq_wd[1]),
    .r1_ready_o(r1_ready), .r1_read_data_o(r1_rd), .r1_read_data_v_o(r1_rdv),
    .addr_o(addr), .write_en_o(we), .read_en_o(re), .op_size_o(size),
    .write_data_o(wdata), .read_data_i(rdata), .read_data_v_i(rdv),
    .timeout_o(tmo), .proto_err_o(perr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- transaction-level model + per-cycle compare ----------------
  int          m_rel;          // clock edges seen since reset release (saturates at 2)
  longint      m_cyc;
  bit          m_last, m_owner, m_pending_strobe, m_pending_write, m_rd_open;
  longint      m_rd_issue_cyc;
  logic [15:0] m_addr;
  logic [1:0]  m_size;
  logic [63:0] m_wdata;

  logic [1:0]  e_rdy, e_rdv, mreq;
  logic [63:0] e_rd [2];
  logic        e_we, e_re, e_to, e_pe, m_done, m_acc, m_g, m_gwe, m_gre;

  initial begin
    m_rel = 0; m_cyc = 0; m_last = 1'b1; m_owner = 1'b0;
    m_pending_strobe = 1'b0; m_pending_write = 1'b0; m_rd_open = 1'b0;
    m_rd_issue_cyc = 0; m_addr = '0; m_size = '0; m_wdata = '0;
  end

  always @(negedge clk) begin
    e_rdy = '0; e_rdv = '0; e_rd[0] = '0; e_rd[1] = '0;
    e_we = 0; e_re = 0; e_to = 0; e_pe = 0; m_done = 0; m_acc = 0;
    m_g = 0; m_gwe = 0; m_gre = 0;
    if (!reset_n) begin
      m_rel = 0; m_last = 1'b1; m_owner = 1'b0; m_pending_strobe = 1'b0;
      m_pending_write = 1'b0; m_rd_open = 1'b0;
      m_addr = '0; m_size = '0; m_wdata = '0;
    end else begin
      mreq = {rq_we[1] | rq_re[1], rq_we[0] | rq_re[0]};
      if (m_pending_strobe) begin
        e_we = m_pending_write;
        e_re = !m_pending_write;
        e_pe = rdv;
      end else if (m_rd_open) begin
        if (rdv) begin
          e_rdv[m_owner] = 1'b1; e_rd[m_owner] = rdata; m_done = 1;
        end else if (m_cyc - m_rd_issue_cyc - 1 == TO) begin
          e_rdv[m_owner] = 1'b1; e_to = 1; m_done = 1;
        end
      end else begin
        e_pe = rdv;
        if (m_rel >= 2 && mreq != 2'b00) begin
          m_g   = (mreq == 2'b11) ? !m_last : mreq[1];
          m_gwe = rq_we[m_g];
          m_gre = rq_re[m_g];
          e_rdy[m_g] = 1'b1;
          if (m_gwe && m_gre) e_pe = 1;
          m_acc = 1;
        end
      end
    end
    chk("ready0", r0_ready, e_rdy[0]);
    chk("ready1", r1_ready, e_rdy[1]);
    chk("rdv0", r0_rdv, e_rdv[0]);
    chk("rdv1", r1_rdv, e_rdv[1]);
    chk("rdata0", r0_rd, e_rd[0]);
    chk("rdata1", r1_rd, e_rd[1]);
    chk("write_en", we, e_we);
    chk("read_en", re, e_re);
    chk("addr", addr, m_addr);
    chk("op_size", size, m_size);
    chk("write_data", wdata, m_wdata);
    chk("timeout", tmo, e_to);
    chk("proto_err", perr, e_pe);
    if (reset_n) begin
      if (m_pending_strobe) begin
        m_pending_strobe = 0;
        if (!m_pending_write) begin m_rd_open = 1; m_rd_issue_cyc = m_cyc; end
      end else if (m_rd_open && m_done) begin
        m_rd_open = 0;
      end else if (m_acc) begin
        m_pending_strobe = 1; m_pending_write = m_gwe; m_owner = m_g; m_last = m_g;
        m_addr = rq_addr[m_g]; m_size = rq_size[m_g]; m_wdata = rq_wd[m_g];
      end
      if (m_rel < 2) m_rel++;
    end
    m_cyc++;
  end

  // ---------------- stimulus ----------------
  logic        s_rdy [2];
  logic        s_rdv [2];
  logic [63:0] s_rd  [2];
  logic        s_we, s_re, s_to, s_pe;
  logic [15:0] s_addr;
  logic [63:0] s_wdata;

  task automatic tick();
    @(negedge clk);
    s_rdy[0] = r0_ready; s_rdy[1] = r1_ready;
    s_rdv[0] = r0_rdv;   s_rdv[1] = r1_rdv;
    s_rd[0]  = r0_rd;    s_rd[1]  = r1_rd;
    s_we = we; s_re = re; s_to = tmo; s_pe = perr; s_addr = addr; s_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic w, input logic r, input logic [15:0] a);
    rq_we[n] = w; rq_re[n] = r; rq_addr[n] = a;
    rq_size[n] = 2'($urandom_range(0, 3));
    rq_wd[n] = {$urandom, $urandom};
  endtask

  bit     pend [2];
  int     resp_cd, rst_hold;
  int     gq[$];

  initial begin
    reset_n = 1'b0; rdv = 1'b0; rdata = '0;
    for (int n = 0; n < 2; n++) set_req(n, 1'b0, 1'b0, 16'h0);
    repeat (3) tick();
    chk("rst_ready0", s_rdy[0], 1'b0);
    chk("rst_addr", s_addr, 16'h0);
    chk("rst_we", s_we, 1'b0);

    // release with a write already pending: two dead cycles, then accept
    reset_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 16'h0010); rq_wd[0] = 64'hA5;
    tick(); chk("post_rst_ready_c0", s_rdy[0], 1'b0);
    tick(); chk("post_rst_ready_c1", s_rdy[0], 1'b0);
    tick(); chk("wr_ready_cyc0", s_rdy[0], 1'b1);
    set_req(0, 1'b1, 1'b0, 16'h0020);
    tick(); chk("wr_we_cyc1", s_we, 1'b1); chk("wr_addr_cyc1", s_addr, 16'h0010);
    chk("wr_data_cyc1", s_wdata, 64'hA5); chk("wr_ready_cyc1", s_rdy[0], 1'b0);
    tick(); chk("wr_we_cyc2", s_we, 1'b0); chk("wr_ready_cyc2", s_rdy[0], 1'b1);
    set_req(0, 1'b0, 1'b0, 16'h0);
    tick(); chk("wr2_addr", s_addr, 16'h0020);
    tick();

    // spurious read data while idle
    rdv = 1'b1; rdata = 64'hDEAD_BEEF;
    tick(); chk("idle_rdv_perr", s_pe, 1'b1); chk("idle_rdv0", s_rdv[0], 1'b0);
    chk("idle_rdv1", s_rdv[1], 1'b0);
    rdv = 1'b0;
    tick(); chk("idle_perr_clear", s_pe, 1'b0);

    // write+read together: write wins, error pulse on acceptance
    set_req(0, 1'b1, 1'b1, 16'h0030);
    tick(); chk("both_ready", s_rdy[0], 1'b1); chk("both_perr", s_pe, 1'b1);
    set_req(0, 1'b0, 1'b0, 16'h0);
    tick(); chk("both_we", s_we, 1'b1); chk("both_re", s_re, 1'b0);
    tick();

    // r1 read with no response: timeout after TO wait cycles
    set_req(1, 1'b0, 1'b1, 16'h0040);
    tick(); chk("to_ready1", s_rdy[1], 1'b1);
    set_req(1, 1'b0, 1'b0, 16'h0);
    tick(); chk("to_re", s_re, 1'b1);
    for (int i = 0; i < TO; i++) begin
      tick(); chk("to_wait_rdv1", s_rdv[1], 1'b0);
    end
    tick(); chk("to_rdv1", s_rdv[1], 1'b1); chk("to_data", s_rd[1], 64'h0);
    chk("to_pulse", s_to, 1'b1); chk("to_rdv0", s_rdv[0], 1'b0);
    set_req(1, 1'b0, 1'b1, 16'h0050);
    tick(); chk("to_next_ready", s_rdy[1], 1'b1); chk("to_pulse_gone", s_to, 1'b0);
    set_req(1, 1'b0, 1'b0, 16'h0);
    tick();
    rdv = 1'b1; rdata = 64'h1234;
    tick(); chk("rd_rdv1", s_rdv[1], 1'b1); chk("rd_data1", s_rd[1], 64'h1234);
    chk("rd_rdv0", s_rdv[0], 1'b0);
    rdv = 1'b0;
    tick();

    // reset in WAIT; late response after release is a protocol error
    set_req(0, 1'b0, 1'b1, 16'h0060);
    tick(); set_req(0, 1'b0, 1'b0, 16'h0);
    tick(); tick();
    reset_n = 1'b0;
    tick(); chk("midrst_addr", s_addr, 16'h0); chk("midrst_rdv0", s_rdv[0], 1'b0);
    chk("midrst_re", s_re, 1'b0); chk("midrst_perr", s_pe, 1'b0);
    tick(); reset_n = 1'b1;
    tick(); rdv = 1'b1; rdata = 64'h77;
    tick(); chk("late_perr", s_pe, 1'b1); chk("late_rdv0", s_rdv[0], 1'b0);
    chk("late_rdv1", s_rdv[1], 1'b0);
    rdv = 1'b0;

    // both read continuously, controller answers one cycle after the strobe
    set_req(0, 1'b0, 1'b1, 16'h0100);
    set_req(1, 1'b0, 1'b1, 16'h0200);
    for (int i = 0; i < 14; i++) begin
      tick();
      if (s_rdy[0]) gq.push_back(0);
      if (s_rdy[1]) gq.push_back(1);
      rdv = s_re; rdata = {$urandom, $urandom};
    end
    chk("rr_count_ge4", 64'(gq.size() >= 4), 64'h1);
    if (gq.size() >= 4) begin
      chk("rr_g0", 64'(gq[0]), 64'h0); chk("rr_g1", 64'(gq[1]), 64'h1);
      chk("rr_g2", 64'(gq[2]), 64'h0); chk("rr_g3", 64'(gq[3]), 64'h1);
    end
    set_req(0, 1'b0, 1'b0, 16'h0); set_req(1, 1'b0, 1'b0, 16'h0);
    rdv = 1'b0;
    repeat (4) tick();

    // randomized traffic
    pend[0] = 0; pend[1] = 0; resp_cd = -1; rst_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset_n = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        reset_n = 1'b0; rst_hold = 2;
      end
      for (int n = 0; n < 2; n++) begin
        if (pend[n] && s_rdy[n]) begin
          pend[n] = 0; set_req(n, 1'b0, 1'b0, rq_addr[n]);
        end else if (pend[n] && $urandom_range(0, 29) == 0) begin
          pend[n] = 0; set_req(n, 1'b0, 1'b0, rq_addr[n]);
        end else if (!pend[n] && $urandom_range(0, 2) == 0) begin
          pend[n] = 1;
          case ($urandom_range(0, 9))
            0:       set_req(n, 1'b1, 1'b1, 16'($urandom));
            1, 2, 3, 4: set_req(n, 1'b1, 1'b0, 16'($urandom));
            default: set_req(n, 1'b0, 1'b1, 16'($urandom));
          endcase
        end
      end
      if (s_re) resp_cd = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO + 2));
      rdv = 1'b0; rdata = {$urandom, $urandom};
      if (resp_cd == 0) begin rdv = 1'b1; resp_cd = -1; end
      else if (resp_cd > 0) resp_cd--;
      else if ($urandom_range(0, 49) == 0) rdv = 1'b1;
    end
    reset_n = 1'b1; rdv = 1'b0;
    set_req(0, 1'b0, 1'b0, 16'h0); set_req(1, 1'b0, 1'b0, 16'h0);
    repeat (TO + 4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
